// File: rtl/jtag_scan_sequencer.sv
// Host-side JTAG master: walks the TAP through reset, IR and DR scans and captures TDO.
// Optional macro JTAG_SEQ_IDLE_PAD_EN appends IDLE_CYCLES Run-Test/Idle cycles after each scan.
module jtag_scan_sequencer #(
  parameter int unsigned MAXLEN      = 32,
  parameter int unsigned LENW        = 6,
  parameter int unsigned IDLE_CYCLES = 4
) (
  input  logic              TCK,
  input  logic              TRST,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [LENW-1:0]   len,
  input  logic [MAXLEN-1:0] din,
  input  logic              TDO,
  output logic              TMS,
  output logic              TDI,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [MAXLEN-1:0] dout
);

  if (((2 ** LENW) <= MAXLEN) || (IDLE_CYCLES > 255)) begin : g_bad_cfg
    $error("jtag_scan_sequencer: need 2**LENW > MAXLEN and IDLE_CYCLES <= 255");
  end

  typedef enum logic [2:0] {
    IDLE, SYNC, HDR, SHIFT, TRL, FIN
`ifdef JTAG_SEQ_IDLE_PAD_EN
    , PAD
`endif
  } state_e;

  localparam logic [2:0]    SYNC_LAST = 3'd5;
  localparam logic [2:0]    TRL_LAST  = 3'd1;
  localparam logic [LENW:0] MAXLEN_W  = (LENW + 1)'(MAXLEN);

`ifdef JTAG_SEQ_IDLE_PAD_EN
  localparam int unsigned PADW     = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [PADW-1:0] PAD_LAST = PADW'(IDLE_CYCLES - 1);
  logic [PADW-1:0] pad_q, pad_d;
`endif

  state_e            state_q, state_d;
  logic              sync_q, sync_d;
  logic              pend_q, pend_d;
  logic              is_ir_q, is_ir_d;
  logic [2:0]        step_q, step_d;
  logic [LENW-1:0]   shcnt_q, shcnt_d;
  logic [LENW-1:0]   len_q, len_d;
  logic [MAXLEN-1:0] din_q, din_d;
  logic [MAXLEN-1:0] dout_q, dout_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    pend_d  = pend_q;
    is_ir_d = is_ir_q;
    step_d  = step_q;
    shcnt_d = shcnt_q;
    len_d   = len_q;
    din_d   = din_q;
    dout_d  = dout_q;
    err_d   = 1'b0;
`ifdef JTAG_SEQ_IDLE_PAD_EN
    pad_d   = pad_q;
`endif

    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start) begin
          if (op == 2'b00) begin
            state_d = SYNC;
            step_d  = '0;
            pend_d  = 1'b0;
          end else if ((op == 2'b11) || (len == '0) || ({1'b0, len} > MAXLEN_W)) begin
            err_d = 1'b1;
          end else begin
            len_d   = len;
            din_d   = din;
            is_ir_d = (op == 2'b01);
            dout_d  = '0;
            shcnt_d = '0;
            step_d  = '0;
            pend_d  = 1'b1;
            state_d = sync_q ? HDR : SYNC;
          end
        end
      end
      SYNC: begin
        if (step_q == SYNC_LAST) begin
          sync_d  = 1'b1;
          step_d  = '0;
          state_d = pend_q ? HDR : FIN;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      HDR: begin
        if (step_q == (is_ir_q ? 3'd3 : 3'd2)) begin
          state_d = SHIFT;
          shcnt_d = '0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      SHIFT: begin
        for (int unsigned i = 0; i < MAXLEN; i++) begin
          if (shcnt_q == LENW'(i)) dout_d[i] = TDO;
        end
        if (shcnt_q == (len_q - LENW'(1))) begin
          state_d = TRL;
          step_d  = '0;
        end else begin
          shcnt_d = shcnt_q + LENW'(1);
        end
      end
      TRL: begin
        if (step_q == TRL_LAST) begin
`ifdef JTAG_SEQ_IDLE_PAD_EN
          state_d = (IDLE_CYCLES == 0) ? FIN : PAD;
          pad_d   = '0;
`else
          state_d = FIN;
`endif
        end else begin
          step_d = step_q + 3'd1;
        end
      end
`ifdef JTAG_SEQ_IDLE_PAD_EN
      PAD: begin
        if (pad_q == PAD_LAST) state_d = FIN;
        else                   pad_d   = pad_q + PADW'(1);
      end
`endif
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered pins line up
    // with the cycle that state represents.
    busy_d = (state_d != IDLE) && (state_d != FIN);
    done_d = (state_d == FIN);
    tdi_d  = 1'b0;
    tms_d  = 1'b0;
    case (state_d)
      IDLE, FIN: tms_d = ~sync_d;
      SYNC:      tms_d = (step_d != SYNC_LAST);
      HDR:       tms_d = is_ir_d ? (step_d < 3'd2) : (step_d == 3'd0);
      SHIFT: begin
        tms_d = (shcnt_d == (len_d - LENW'(1)));
        for (int unsigned i = 0; i < MAXLEN; i++) begin
          if (shcnt_d == LENW'(i)) tdi_d = din_d[i];
        end
      end
      TRL:       tms_d = (step_d == 3'd0);
      default:   tms_d = 1'b0;
    endcase
  end

  always_ff @(posedge TCK) begin
    if (TRST) begin
      state_q <= IDLE;
      sync_q  <= 1'b0;
      pend_q  <= 1'b0;
      is_ir_q <= 1'b0;
      step_q  <= '0;
      shcnt_q <= '0;
      len_q   <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef JTAG_SEQ_IDLE_PAD_EN
      pad_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      pend_q  <= pend_d;
      is_ir_q <= is_ir_d;
      step_q  <= step_d;
      shcnt_q <= shcnt_d;
      len_q   <= len_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef JTAG_SEQ_IDLE_PAD_EN
      pad_q   <= pad_d;
`endif
    end
  end

  assign TMS  = tms_q;
  assign TDI  = tdi_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign dout = dout_q;

endmodule
